vsm_phase_sequencer: RTL

Sequencer for the VSM 4-bit processor. It generates the one-hot Phase0..Phase3 strobes that drive the microinstruction decoder, and it owns the program counter. It also provides run, single-step and halt control, and stalls the phase ring on memory-fetch and I/O handshakes. It sits between the clock/reset source and the microinstruction decoder, and is the only block that advances instruction execution.

---
 rtl/vsm_phase_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vsm_phase_sequencer.sv
// Phase sequencer for the VSM 4-bit processor: one-hot Phase0..Phase3 strobes,
// program counter, run/step/halt control and fetch/I-O handshake stalls.
module vsm_phase_sequencer #(
   parameter int         PC_WIDTH = 4,
   parameter logic [3:0] OPC_HALT = 4'b1111,
   parameter logic [3:0] OPC_OUT  = 4'b0011,
   parameter logic [3:0] OPC_IN   = 4'b0100
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Run,
   input  logic                Step,
   input  logic [3:0]          InstrIn,
   input  logic                MemReady,
   input  logic                InValid,
   input  logic                OutAck,
   output logic                Phase0,
   output logic                Phase1,
   output logic                Phase2,
   output logic                Phase3,
   output logic [PC_WIDTH-1:0] Pc,
   output logic                InReq,
   output logic                OutReq,
   output logic                InstrDone,
   output logic                Halted,
   output logic                Idle
);

   // Phase states are numbered so that phase N is encoded as N+1.
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_P0   = 3'd1;
   localparam logic [2:0] ST_P1   = 3'd2;
   localparam logic [2:0] ST_P2   = 3'd3;
   localparam logic [2:0] ST_P3   = 3'd4;
   localparam logic [2:0] ST_HALT = 3'd5;

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]          state_reg, state_next;
   logic [PC_WIDTH-1:0] pc_reg, pc_next;
   logic                oneshot_reg, oneshot_next;
   logic [3:0]          phase_reg, phase_next;
   logic                idle_reg, halted_reg;
   logic                opc_in, opc_out, p2_hold;

   assign opc_in  = (InstrIn == OPC_IN);
   assign opc_out = (InstrIn == OPC_OUT);
   assign p2_hold = (opc_in && !InValid) || (opc_out && !OutAck);

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      oneshot_next = oneshot_reg;
      case (state_reg)
         ST_IDLE: begin
            if (Run) begin
               state_next   = ST_P0;
               oneshot_next = 1'b0;
            end else if (Step) begin
               state_next   = ST_P0;
               oneshot_next = 1'b1;
            end
         end
         ST_P0: begin
            if (MemReady) begin
               state_next = ST_P1;
            end
         end
         ST_P1: begin
            if (InstrIn == OPC_HALT) begin
               state_next = ST_HALT;
            end else begin
               pc_next    = pc_reg + PC_ONE;
               state_next = ST_P2;
            end
         end
         ST_P2: begin
            if (!p2_hold) begin
               state_next = ST_P3;
            end
         end
         ST_P3: begin
            // A single-stepped instruction always parks, even if Run rose meanwhile.
            if (Run && !oneshot_reg) begin
               state_next = ST_P0;
            end else begin
               state_next   = ST_IDLE;
               oneshot_next = 1'b0;
            end
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_phase
         assign phase_next[gi] = (state_next == 3'(gi + 1));
      end
   endgenerate

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg   <= ST_IDLE;
         pc_reg      <= '0;
         oneshot_reg <= 1'b0;
         phase_reg   <= 4'b0000;
         idle_reg    <= 1'b1;
         halted_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         oneshot_reg <= oneshot_next;
         phase_reg   <= phase_next;
         idle_reg    <= (state_next == ST_IDLE);
         halted_reg  <= (state_next == ST_HALT);
      end
   end

   assign Phase0    = phase_reg[0];
   assign Phase1    = phase_reg[1];
   assign Phase2    = phase_reg[2];
   assign Phase3    = phase_reg[3];
   assign Pc        = pc_reg;
   assign InReq     = phase_reg[2] && opc_in;
   assign OutReq    = phase_reg[2] && opc_out;
   assign InstrDone = phase_reg[3];
   assign Halted    = halted_reg;
   assign Idle      = idle_reg;

endmodule
